byteswap_stream: RTL and testbench
==================================

# byteswap_stream

Parametrised streaming byte-reorder engine: the datapath successor to the fixed 32-bit byteswap kernel core. It sits between the gmem read and write movers. It accepts an AXI4-Stream of C_DATA_WIDTH-bit beats and applies a runtime-selected reorder mode to every C_WORD_BIT_WIDTH word lane. It emits a counted transfer of xfer_size beats with TLAST and an ap_done pulse. A 2-entry skid buffer gives full throughput under back-pressure.

## Interface
- C_DATA_WIDTH, 512: stream beat width. Must be a multiple of C_WORD_BIT_WIDTH.
- C_WORD_BIT_WIDTH, 32: lane width. Must be a multiple of 2*C_BYTE_BIT_WIDTH.
- C_BYTE_BIT_WIDTH, 8: reorder unit.
- C_XFER_SIZE_WIDTH, 32: beat-counter width.
- ap_clk  in  1  sole clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse on transfer completion.
- mode  in  2  reorder mode; latched on the ap_start accept.
- xfer_size  in  C_XFER_SIZE_WIDTH  beats to transfer; latched on the ap_start accept.
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
- s_axis_tdata  in  C_DATA_WIDTH  input beat.
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
- m_axis_tdata  out  C_DATA_WIDTH  reordered beat.
- m_axis_tlast  out  1  high with final beat.

## Operation
- Reset values:
  - ap_idle=1.
  - ap_done=0.
  - s_axis_tready=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - State IDLE; counters 0; buffer empty.
- Reset mid-transfer discards all buffered beats. Outputs take their reset values in the cycle after areset is sampled high.
- Modes are applied per word lane k; lane bytes are indexed b0 = least significant.
  - 0: passthrough.
  - 1: full byte reverse within the lane (b0<->bN-1 …).
  - 2: half swap, upper and lower lane halves exchanged; byte order inside each half is kept.
  - 3: full-beat byte reverse. Lane order is reversed and each lane is byte-reversed, so beat byte i maps to byte C_DATA_WIDTH/8-1-i.
- State IDLE
  - ap_start=1 latches mode and xfer_size and clears in_cnt/out_cnt.
  - Next state is DONE if xfer_size==0, else RUN.
- State RUN
  - s_axis_tready = (in_cnt < xfer_size_q) && buffer not full.
  - Each input handshake increments in_cnt and pushes the reordered beat.
  - Each output handshake increments out_cnt.
  - m_axis_tlast = (out_cnt == xfer_size_q-1) for the beat at the head of the buffer.
  - Handshake on the tlast beat -> DONE.
- State DONE: ap_done=1 for exactly one cycle, then IDLE.
- ap_start outside IDLE is ignored.
- Input beats are never accepted beyond xfer_size_q. Extra upstream beats remain pending for the next transfer.
- Counter widths are C_XFER_SIZE_WIDTH. The maximum xfer_size (all ones) must complete without wrap.
- Reorder is pure wiring ahead of buffer entry. The buffer is a 2-entry skid: a main register plus a skid register.
- Simultaneous push and pop:
  - With 1 entry held, occupancy stays 1 and throughput is 1 beat/cycle.
  - With 2 entries held, pop only; s_axis_tready is low.

## Timing
- Start: ap_start sampled at cycle t -> RUN at t+1. s_axis_tready is high at t+1 if xfer_size>0.
- Latency: input handshake at cycle t -> m_axis_tvalid and data valid at t+1 (registered, 1 cycle).
- Throughput: 1 beat/cycle sustained while m_axis_tready=1.
- s_axis_tready is a registered function of occupancy; it deasserts the cycle after the buffer reaches 2 entries.
- m_axis_tvalid, once asserted, holds with stable tdata/tlast until the handshake (AXI-Stream rule).
- Completion: final output handshake at t -> ap_done=1 at t+1 (ap_idle=0) -> ap_idle=1 at t+2.
- xfer_size==0: ap_start at t -> ap_done at t+1, no stream activity.
- mode and xfer_size inputs may change freely outside the start cycle.

## Test plan
- Mode 1, C_DATA_WIDTH=64, xfer_size=2, beats 0x0011223344556677 and 0x8899AABBCCDDEEFF, m_axis_tready=1.
  - Output: 0x3322110077665544 and 0xBBAA9988FFEEDDCC.
  - tlast only on beat 2.
  - First output 1 cycle after input.
  - ap_done 1 cycle after the last handshake.
- Modes 0/2/3 on beat 0x0011223344556677.
  - Mode 0: 0x0011223344556677.
  - Mode 2: 0x2233001166774455.
  - Mode 3: 0x7766554433221100.
- Back-pressure: xfer_size=16, m_axis_tready pseudo-random 50%, upstream always valid.
  - All 16 beats delivered in order, none dropped or duplicated.
  - s_axis_tready never high with 2 entries held.
  - Exactly 16 input handshakes.
- xfer_size=0 with ap_start.
  - ap_done at t+1.
  - s_axis_tready stays 0.
  - m_axis_tvalid stays 0.
- Reset mid-transfer: areset for 1 cycle after 3 of 8 beats, with 2 buffered.
  - Next cycle: m_axis_tvalid=0, s_axis_tready=0, ap_idle=1.
  - A new start with xfer_size=4 completes normally with tlast on beat 4.
- ap_start pulsed during RUN is ignored; exactly one ap_done. Upstream offers 5 beats with xfer_size=3; only 3 are accepted.

Source files
------------

// File: rtl/byteswap_stream_if.sv
// -----------------------------------------------------------------------------
// byteswap_stream_if
// -----------------------------------------------------------------------------
// Purpose:
//   AXI4-Stream style bundle used on both sides of the byte-reorder engine.
//   A single definition serves the input and output streams. The modport
//   decides which side drives which signal.
//
// Signals:
//   tvalid  producer -> consumer  beat is valid
//   tready  consumer -> producer  consumer can take the beat
//   tdata   producer -> consumer  DATA_WIDTH-bit beat
//   tlast   producer -> consumer  final beat of the transfer
//
// Modports:
//   master  drives tvalid/tdata/tlast and samples tready
//   slave   samples tvalid/tdata and drives tready. tlast is not consumed
//           on the input side of this engine, so it is left out here.
// -----------------------------------------------------------------------------
interface byteswap_stream_if #(
   parameter int DATA_WIDTH = 512
) ();

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   // Producer side of the stream
   modport master (
      output tvalid,
      output tdata,
      output tlast,
      input  tready
   );

   // Consumer side of the stream
   modport slave (
      input  tvalid,
      input  tdata,
      output tready
   );

endinterface

// File: rtl/byteswap_stream.sv
// -----------------------------------------------------------------------------
// byteswap_stream
// -----------------------------------------------------------------------------
// Purpose:
//   Streaming byte-reorder engine that sits between the gmem read and write
//   movers. A transfer is started with ap_start. Mode and beat count are
//   latched when the start is accepted. Every input beat is reordered lane by
//   lane and pushed into a 2-entry skid buffer. Exactly xfer_size beats are
//   emitted, and the final beat carries tlast. ap_done pulses for one cycle
//   when the transfer completes.
//
// Reorder modes (applied to each C_WORD_BIT_WIDTH lane; byte 0 is the least
// significant byte):
//   0  passthrough
//   1  byte reverse within each lane
//   2  swap the upper and lower halves of each lane, keeping byte order
//      inside each half
//   3  byte reverse across the whole beat (beat byte i -> byte NB-1-i)
//
// Ports:
//   ap_clk     in   sole clock, rising edge
//   areset     in   synchronous active-high reset
//   ap_start   in   start request, only looked at while idle
//   ap_idle    out  high while idle
//   ap_done    out  one-cycle completion pulse
//   mode       in   reorder mode, latched on start
//   xfer_size  in   beats to transfer, latched on start
//   s_axis     slave stream (tvalid/tready/tdata)
//   m_axis     master stream (tvalid/tready/tdata/tlast)
// -----------------------------------------------------------------------------
module byteswap_stream #(
   parameter int C_DATA_WIDTH      = 512,
   parameter int C_WORD_BIT_WIDTH  = 32,
   parameter int C_BYTE_BIT_WIDTH  = 8,
   parameter int C_XFER_SIZE_WIDTH = 32
) (
   input  logic                         ap_clk,
   input  logic                         areset,
   input  logic                         ap_start,
   output logic                         ap_idle,
   output logic                         ap_done,
   input  logic [1:0]                   mode,
   input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size,
   byteswap_stream_if.slave             s_axis,
   byteswap_stream_if.master            m_axis
);

   // Number of reorder units per beat and per lane
   localparam int NB = C_DATA_WIDTH / C_BYTE_BIT_WIDTH;
   localparam int LB = C_WORD_BIT_WIDTH / C_BYTE_BIT_WIDTH;
   localparam int BW = C_BYTE_BIT_WIDTH;

   localparam logic [C_XFER_SIZE_WIDTH-1:0] CntOne = {{(C_XFER_SIZE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [C_XFER_SIZE_WIDTH-1:0] CntZero = '0;

   // Controller states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                   r_state;
   logic [1:0]                   r_modeQ;
   logic [C_XFER_SIZE_WIDTH-1:0] r_xferSizeQ;
   logic [C_XFER_SIZE_WIDTH-1:0] r_inCnt;
   logic [C_XFER_SIZE_WIDTH-1:0] r_outCnt;

   // Skid buffer storage. The main register is the output head. The skid
   // register only ever holds a beat while the main register is also full.
   logic [C_DATA_WIDTH-1:0]      r_mainData;
   logic                         r_mainValid;
   logic [C_DATA_WIDTH-1:0]      r_skidData;
   logic                         r_skidValid;

   logic [C_DATA_WIDTH-1:0]      w_byteRev;
   logic [C_DATA_WIDTH-1:0]      w_halfSwap;
   logic [C_DATA_WIDTH-1:0]      w_beatRev;
   logic [C_DATA_WIDTH-1:0]      w_reordered;
   logic                         w_sReady;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_lastHead;

   // The three non-trivial reorders are pure wiring. Each output byte gB picks
   // its source byte from the lane it lives in (modes 1 and 2) or from the
   // mirrored position across the whole beat (mode 3).
   genvar gB;
   generate
      for (gB = 0; gB < NB; gB++) begin : g_byte
         localparam int LANE = gB / LB;
         localparam int POS  = gB % LB;
         assign w_byteRev[gB*BW +: BW]  = s_axis.tdata[(LANE*LB + (LB-1-POS))*BW +: BW];
         assign w_halfSwap[gB*BW +: BW] = s_axis.tdata[(LANE*LB + ((POS + LB/2) % LB))*BW +: BW];
         assign w_beatRev[gB*BW +: BW]  = s_axis.tdata[(NB-1-gB)*BW +: BW];
      end
   endgenerate

   // Select the reorder using the mode latched at start, so the mode input
   // is free to change while a transfer is running.
   always_comb begin
      w_reordered = s_axis.tdata;
      case (r_modeQ)
         2'd1:    w_reordered = w_byteRev;
         2'd2:    w_reordered = w_halfSwap;
         2'd3:    w_reordered = w_beatRev;
         default: w_reordered = s_axis.tdata;
      endcase
   end

   // Input is accepted only while running, while beats are still owed, and
   // while the skid slot is free. This depends only on registered state, so
   // tready drops the cycle after the buffer fills. It never depends
   // combinationally on the downstream tready.
   assign w_sReady = (r_state == ST_RUN) && (r_inCnt < r_xferSizeQ) && !r_skidValid;
   assign w_push   = s_axis.tvalid && w_sReady;
   assign w_pop    = r_mainValid && m_axis.tready;

   // The head beat is the last one when exactly xfer_size-1 beats have already
   // left. The output counter only moves on a handshake, so tlast stays stable
   // while the head waits.
   assign w_lastHead = r_mainValid && (r_outCnt == (r_xferSizeQ - CntOne));

   assign s_axis.tready = w_sReady;
   assign m_axis.tvalid = r_mainValid;
   assign m_axis.tdata  = r_mainData;
   assign m_axis.tlast  = w_lastHead;

   assign ap_idle = (r_state == ST_IDLE);
   assign ap_done = (r_state == ST_DONE);

   // Transfer controller. IDLE waits for a start and latches the job. RUN
   // counts beats in and out. DONE is held for exactly one cycle to form the
   // ap_done pulse. A zero-length job goes straight to DONE and never opens
   // the input.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_state     <= ST_IDLE;
         r_modeQ     <= 2'd0;
         r_xferSizeQ <= CntZero;
         r_inCnt     <= CntZero;
         r_outCnt    <= CntZero;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ap_start) begin
                  r_modeQ     <= mode;
                  r_xferSizeQ <= xfer_size;
                  r_inCnt     <= CntZero;
                  r_outCnt    <= CntZero;
                  r_state     <= (xfer_size == CntZero) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_push) begin
                  r_inCnt <= r_inCnt + CntOne;
               end
               if (w_pop) begin
                  r_outCnt <= r_outCnt + CntOne;
                  if (w_lastHead) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Two-entry skid buffer. A push into an empty buffer lands in the main
   // register. A push while the head is stalled lands in the skid register.
   // A pop refills the head from the skid register if it holds a beat.
   // Push and pop together can only happen with the skid register empty,
   // because input is gated on that. The new beat then simply replaces the
   // departing head, which keeps one beat per cycle flowing.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_mainData  <= '0;
         r_mainValid <= 1'b0;
         r_skidData  <= '0;
         r_skidValid <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (!r_mainValid) begin
                  r_mainData  <= w_reordered;
                  r_mainValid <= 1'b1;
               end else begin
                  r_skidData  <= w_reordered;
                  r_skidValid <= 1'b1;
               end
            end
            2'b01: begin
               if (r_skidValid) begin
                  r_mainData  <= r_skidData;
                  r_skidValid <= 1'b0;
               end else begin
                  r_mainValid <= 1'b0;
               end
            end
            2'b11: begin
               r_mainData <= w_reordered;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byteswap_stream.sv
// -----------------------------------------------------------------------------
// tb_byteswap_stream
// -----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for byteswap_stream at 64-bit beats and 32-bit lanes.
//   A behavioural model follows each transfer as a queue of expected beats,
//   and a negedge compare process checks every DUT output against it on every
//   cycle. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_byteswap_stream;

   localparam int DW = 64;
   localparam int WW = 32;
   localparam int BW = 8;
   localparam int XW = 32;

   logic          ap_clk = 1'b0;
   logic          areset = 1'b1;
   logic          ap_start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [XW-1:0] xfer_size = '0;
   logic          ap_idle;
   logic          ap_done;

   byteswap_stream_if #(.DATA_WIDTH(DW)) s_if ();
   byteswap_stream_if #(.DATA_WIDTH(DW)) m_if ();

   byteswap_stream #(
      .C_DATA_WIDTH(DW),
      .C_WORD_BIT_WIDTH(WW),
      .C_BYTE_BIT_WIDTH(BW),
      .C_XFER_SIZE_WIDTH(XW)
   ) dut (
      .ap_clk(ap_clk),
      .areset(areset),
      .ap_start(ap_start),
      .ap_idle(ap_idle),
      .ap_done(ap_done),
      .mode(mode),
      .xfer_size(xfer_size),
      .s_axis(s_if),
      .m_axis(m_if)
   );

   always #5 ap_clk = ~ap_clk;

   int compared = 0;
   int mismatched = 0;

   // Stimulus and statistics shared between processes
   logic [DW-1:0] srcQ[$];
   int            readyPct = 100;
   bit            srcTake = 1'b0;
   bit            monEn = 1'b0;
   int            cyc = 0;

   int            inHs, outHs, doneCnt;
   int            firstInCyc, firstOutCyc, lastOutCyc, doneCyc, startCyc;
   logic [DW-1:0] gotData[$];
   bit            gotLast[$];

   // Behavioural model state
   int              phase = 0;
   logic [1:0]      mMode = 2'd0;
   longint unsigned mXfer = 0, mIn = 0, mOut = 0;
   logic [DW-1:0]   expQ[$];

   // Compare one observed value against the expectation and log a mismatch
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Byte-level reference reorder. Bytes are pulled into an array and
   // rearranged according to the plain-language rule for each mode.
   function automatic logic [DW-1:0] refReorder(input logic [1:0] md, input logic [DW-1:0] beat);
      byte unsigned bIn[DW/8];
      byte unsigned bOut[DW/8];
      logic [DW-1:0] res;
      int nb = DW / 8;
      int lb = WW / 8;
      for (int i = 0; i < nb; i++) bIn[i] = beat[i*8 +: 8];
      for (int i = 0; i < nb; i++) bOut[i] = bIn[i];
      if (md == 2'd3) begin
         for (int i = 0; i < nb; i++) bOut[i] = bIn[nb-1-i];
      end else if (md != 2'd0) begin
         for (int lane = 0; lane < nb / lb; lane++) begin
            for (int p = 0; p < lb; p++) begin
               if (md == 2'd1) bOut[lane*lb + p] = bIn[lane*lb + (lb-1-p)];
               else            bOut[lane*lb + p] = bIn[lane*lb + ((p + lb/2) % lb)];
            end
         end
      end
      res = '0;
      for (int i = 0; i < nb; i++) res[i*8 +: 8] = bOut[i];
      return res;
   endfunction

   // Compare process plus model update. The negedge view equals what the next
   // rising edge will sample, so handshakes seen here are the ones about to
   // happen.
   always @(negedge ap_clk) begin
      bit expReady;
      bit hsIn;
      bit hsOut;
      cyc++;
      expReady = (phase == 1) && (mIn < mXfer) && (expQ.size() < 2);
      if (monEn) begin
         checkOutput("ap_idle", 64'(ap_idle), 64'(phase == 0));
         checkOutput("ap_done", 64'(ap_done), 64'(phase == 2));
         checkOutput("s_tready", 64'(s_if.tready), 64'(expReady));
         checkOutput("m_tvalid", 64'(m_if.tvalid), 64'(expQ.size() > 0));
         if (m_if.tvalid === 1'b1 && expQ.size() > 0) begin
            checkOutput("m_tdata", m_if.tdata, expQ[0]);
            checkOutput("m_tlast", 64'(m_if.tlast), 64'(mOut == mXfer - 1));
         end
      end
      if (ap_done === 1'b1) begin
         doneCnt++;
         if (doneCyc < 0) doneCyc = cyc;
      end
      hsIn  = (s_if.tvalid === 1'b1) && (s_if.tready === 1'b1) && !areset;
      hsOut = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b1) && !areset;
      srcTake = hsIn;
      if (hsIn) begin
         inHs++;
         if (firstInCyc < 0) firstInCyc = cyc;
      end
      if (areset) begin
         phase = 0;
         expQ.delete();
      end else begin
         case (phase)
            0: begin
               if (ap_start) begin
                  mMode = mode;
                  mXfer = longint'(xfer_size);
                  mIn = 0;
                  mOut = 0;
                  startCyc = cyc;
                  phase = (xfer_size == 0) ? 2 : 1;
               end
            end
            2: phase = 0;
            default: begin
               if (hsOut) begin
                  gotData.push_back(m_if.tdata);
                  gotLast.push_back(m_if.tlast);
                  outHs++;
                  if (firstOutCyc < 0) firstOutCyc = cyc;
                  lastOutCyc = cyc;
                  if (expQ.size() > 0) void'(expQ.pop_front());
                  if (mOut == mXfer - 1) phase = 2;
                  mOut++;
               end
               if (hsIn) begin
                  expQ.push_back(refReorder(mMode, s_if.tdata));
                  mIn++;
               end
            end
         endcase
      end
   end

   // Upstream source and downstream ready generator
   always @(posedge ap_clk) begin
      #1;
      if (srcTake && srcQ.size() > 0) void'(srcQ.pop_front());
      s_if.tvalid = (srcQ.size() > 0);
      s_if.tdata  = (srcQ.size() > 0) ? srcQ[0] : '0;
      if (readyPct >= 100)    m_if.tready = 1'b1;
      else if (readyPct <= 0) m_if.tready = 1'b0;
      else                    m_if.tready = ($urandom_range(0, 99) < readyPct);
   end

   task automatic clearStats();
      inHs = 0; outHs = 0; doneCnt = 0;
      firstInCyc = -1; firstOutCyc = -1; lastOutCyc = -1; doneCyc = -1; startCyc = -1;
      gotData.delete();
      gotLast.delete();
   endtask

   // Issue a one-cycle start, then scramble mode/xfer_size to show they are
   // only taken on the start cycle
   task automatic applyStimulus(input logic [1:0] md, input logic [XW-1:0] size);
      @(posedge ap_clk); #1;
      mode = md;
      xfer_size = size;
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      mode = 2'($urandom);
      xfer_size = $urandom;
   endtask

   task automatic waitDone(input int limit);
      int n = 0;
      while (doneCnt == 0 && n < limit) begin
         @(negedge ap_clk); #1;
         n++;
      end
      compared++;
      if (doneCnt == 0) begin
         mismatched++;
         $display("[TB] FAIL done_timeout: got no ap_done, expected one within %0d cycles", limit);
      end
      @(negedge ap_clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [1:0]  tMode[3] = '{2'd0, 2'd2, 2'd3};
   logic [63:0] tExp[3]  = '{64'h0011223344556677, 64'h2233001166774455, 64'h7766554433221100};

   initial begin
      logic [3:0] lastBits;
      int         n;
      logic [1:0] md;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b0;
      clearStats();

      // Reset and check reset values
      areset = 1'b1;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk); #1;
      monEn = 1'b1;
      checkOutput("reset_ap_idle", 64'(ap_idle), 64'd1);
      checkOutput("reset_ap_done", 64'(ap_done), 64'd0);
      checkOutput("reset_s_tready", 64'(s_if.tready), 64'd0);
      checkOutput("reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
      checkOutput("reset_m_tlast", 64'(m_if.tlast), 64'd0);
      checkOutput("reset_m_tdata", m_if.tdata, 64'd0);
      @(posedge ap_clk); #1;
      areset = 1'b0;
      @(negedge ap_clk); #1;

      // Mode 1, two beats, free-flowing output
      $display("[TB] mode 1 directed transfer");
      clearStats();
      srcQ.push_back(64'h0011223344556677);
      srcQ.push_back(64'h8899AABBCCDDEEFF);
      readyPct = 100;
      applyStimulus(2'd1, 32'd2);
      waitDone(50);
      checkOutput("m1_count", 64'(outHs), 64'd2);
      checkOutput("m1_beat0", gotData[0], 64'h3322110077665544);
      checkOutput("m1_beat1", gotData[1], 64'hBBAA9988FFEEDDCC);
      checkOutput("m1_last0", 64'(gotLast[0]), 64'd0);
      checkOutput("m1_last1", 64'(gotLast[1]), 64'd1);
      checkOutput("m1_latency", 64'(firstOutCyc - firstInCyc), 64'd1);
      checkOutput("m1_done_delay", 64'(doneCyc - lastOutCyc), 64'd1);

      // Remaining modes on a single beat
      for (int t = 0; t < 3; t++) begin
         $display("[TB] mode %0d single beat", tMode[t]);
         clearStats();
         srcQ.push_back(64'h0011223344556677);
         applyStimulus(tMode[t], 32'd1);
         waitDone(50);
         checkOutput("mode_beat", gotData[0], tExp[t]);
         checkOutput("mode_last", 64'(gotLast[0]), 64'd1);
      end

      // Back-pressure with random data, random mode, upstream always valid
      $display("[TB] back-pressure transfer");
      clearStats();
      for (int i = 0; i < 20; i++) srcQ.push_back({$urandom, $urandom});
      md = 2'($urandom_range(0, 3));
      readyPct = 50;
      applyStimulus(md, 32'd16);
      waitDone(1000);
      checkOutput("bp_in_count", 64'(inHs), 64'd16);
      checkOutput("bp_out_count", 64'(outHs), 64'd16);
      checkOutput("bp_pending", 64'(srcQ.size()), 64'd4);
      srcQ.delete();
      readyPct = 100;
      @(negedge ap_clk); #1;

      // Zero-length transfer with upstream offering a beat
      $display("[TB] zero-length transfer");
      clearStats();
      srcQ.push_back(64'hDEADBEEFCAFEF00D);
      applyStimulus(2'($urandom_range(0, 3)), 32'd0);
      waitDone(20);
      checkOutput("zero_done_delay", 64'(doneCyc - startCyc), 64'd1);
      checkOutput("zero_in_count", 64'(inHs), 64'd0);
      checkOutput("zero_out_count", 64'(outHs), 64'd0);
      srcQ.delete();
      @(negedge ap_clk); #1;

      // Reset after three of eight beats with two held in the buffer
      $display("[TB] reset mid-transfer");
      clearStats();
      for (int i = 0; i < 8; i++) srcQ.push_back({$urandom, $urandom});
      readyPct = 100;
      applyStimulus(2'($urandom_range(0, 3)), 32'd8);
      n = 0;
      while (outHs < 1 && n < 20) begin @(negedge ap_clk); #1; n++; end
      readyPct = 0;
      n = 0;
      while (inHs < 3 && n < 20) begin @(negedge ap_clk); #1; n++; end
      @(negedge ap_clk); #1;
      checkOutput("rst_pre_in_count", 64'(inHs), 64'd3);
      checkOutput("rst_pre_m_tvalid", 64'(m_if.tvalid), 64'd1);
      checkOutput("rst_pre_s_tready", 64'(s_if.tready), 64'd0);
      @(posedge ap_clk); #1;
      areset = 1'b1;
      srcQ.delete();
      @(posedge ap_clk); #1;
      areset = 1'b0;
      @(negedge ap_clk); #1;
      checkOutput("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      checkOutput("rst_s_tready", 64'(s_if.tready), 64'd0);
      checkOutput("rst_ap_idle", 64'(ap_idle), 64'd1);

      // Fresh four-beat transfer after the reset
      clearStats();
      readyPct = 100;
      for (int i = 0; i < 4; i++) srcQ.push_back({$urandom, $urandom});
      applyStimulus(2'($urandom_range(0, 3)), 32'd4);
      waitDone(50);
      checkOutput("post_rst_count", 64'(outHs), 64'd4);
      for (int i = 0; i < 4; i++) lastBits[i] = (i < gotLast.size()) ? gotLast[i] : 1'b0;
      checkOutput("post_rst_tlast", 64'(lastBits), 64'b1000);

      // ap_start pulsed during RUN, upstream offers more than requested
      $display("[TB] start during run");
      clearStats();
      for (int i = 0; i < 5; i++) srcQ.push_back({$urandom, $urandom});
      readyPct = 50;
      applyStimulus(2'($urandom_range(0, 3)), 32'd3);
      ap_start = 1'b1;
      xfer_size = 32'd0;
      @(posedge ap_clk); #1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      waitDone(200);
      repeat (6) @(negedge ap_clk);
      #1;
      checkOutput("run_start_done_count", 64'(doneCnt), 64'd1);
      checkOutput("run_start_in_count", 64'(inHs), 64'd3);
      checkOutput("run_start_pending", 64'(srcQ.size()), 64'd2);
      srcQ.delete();
      readyPct = 100;
      repeat (3) @(negedge ap_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
